fifo_bytepack: RTL and testbench

- Parametrised byte-stream FIFO that accepts variable-width multi-byte writes (1..MaxWriteBytes bytes per cycle) and delivers one byte per ack.
- Sits between the UART command/decoder path and the UART transmitter, which pops bytes with ack.
- Generalises the two-byte-buffer-plus-memory scheme into a single circular byte store with:
  - configurable depth and write width,
  - selectable byte order,
  - all-or-nothing write acceptance, occupancy reporting, sticky overflow and flush.

---
 rtl/fifo_bytepack.sv | 119 +++++++++++
 tb/tb_fifo_bytepack.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_bytepack.sv
// fifo_bytepack
//   Circular byte FIFO between the command/decoder path and the UART
//   transmitter. Each cycle it accepts a write of 1..MaxWriteBytes bytes,
//   and it hands out one byte per ack. A write is either stored whole or
//   not at all. The block also reports occupancy, keeps a sticky overflow
//   flag and supports a synchronous flush.
//
// Ports
//   clk_i         clock, rising edge
//   reset_i       synchronous active-high reset (clears the array as well)
//   flush         synchronous clear of pointers, level and overflow
//   write_enable  write request this cycle
//   write_data    payload; only the low write_width bytes are used
//   write_width   number of valid bytes, 0..MaxWriteBytes
//   write_ready   free_bytes >= MaxWriteBytes
//   free_bytes    Depth - level
//   level         stored byte count
//   ack           consumer pops the head byte
//   data          head byte (valid while have_next)
//   have_next     level != 0
//   overflow      sticky: a write was rejected
module fifo_bytepack #(
    parameter int unsigned Depth         = 16,
    parameter int unsigned MaxWriteBytes = 4,
    parameter bit          LittleEndian  = 1'b0
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 flush,
    input  logic                                 write_enable,
    input  logic [8*MaxWriteBytes-1:0]           write_data,
    input  logic [$clog2(MaxWriteBytes+1)-1:0]   write_width,
    output logic                                 write_ready,
    output logic [$clog2(Depth+1)-1:0]           free_bytes,
    output logic [$clog2(Depth+1)-1:0]           level,
    input  logic                                 ack,
    output logic [7:0]                           data,
    output logic                                 have_next,
    output logic                                 overflow
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = $clog2(Depth+1);

    logic [7:0]      mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0] level_q, level_d;
    logic            overflow_q, overflow_d;

    logic [31:0]     w32;
    logic [31:0]     free32;
    logic            wr_req;
    logic            accept;
    logic            pop;
    logic [7:0]      wbyte [MaxWriteBytes];

    // Output decode straight from the registers.
    assign data        = mem_q[rd_ptr_q];
    assign have_next   = (level_q != '0);
    assign free_bytes  = LvlW'(Depth) - level_q;
    assign write_ready = (32'(free_bytes) >= MaxWriteBytes);
    assign level       = level_q;
    assign overflow    = overflow_q;

    always_comb begin
        w32    = 32'(write_width);
        free32 = 32'(free_bytes);
        wr_req = write_enable && (w32 != 32'd0);
        // Free space is judged on the pre-cycle level, so a pop in the
        // same cycle does not make room for the write.
        accept = wr_req && (w32 <= MaxWriteBytes) && (w32 <= free32);
        pop    = ack && have_next;

        level_d    = level_q + (accept ? LvlW'(write_width) : '0) - LvlW'(pop);
        wr_ptr_d   = accept ? wr_ptr_q + PtrW'(write_width) : wr_ptr_q;
        rd_ptr_d   = rd_ptr_q + PtrW'(pop);
        overflow_d = overflow_q | (wr_req && !accept);

        // wbyte[k] is the k-th byte in emission order.
        for (int unsigned k = 0; k < MaxWriteBytes; k++) begin
            wbyte[k] = '0;
            for (int unsigned j = 0; j < MaxWriteBytes; j++) begin
                if (LittleEndian ? (j == k) : (j + k + 1 == w32)) begin
                    wbyte[k] = write_data[j*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            // The array keeps its old contents. Only the bookkeeping is cleared.
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            for (int unsigned k = 0; k < MaxWriteBytes; k++) begin
                if (accept && (k < w32)) begin
                    mem_q[wr_ptr_q + PtrW'(k)] <= wbyte[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_bytepack.sv
// tb_fifo_bytepack
//   Two instances of fifo_bytepack, one big-endian and one little-endian,
//   receive the same stimulus. Each instance is compared every cycle with a
//   queue-based byte model. Directed scenarios come first, then random
//   traffic.
module tb_fifo_bytepack;

    localparam int unsigned Depth = 16;
    localparam int unsigned MaxWB = 4;

    logic        clk_i = 1'b0;
    logic        reset_i, flush, write_enable, ack;
    logic [31:0] write_data;
    logic [2:0]  write_width;

    logic       ready0, ready1, hn0, hn1, ovf0, ovf1;
    logic [4:0] free0, free1, lvl0, lvl1;
    logic [7:0] data0, data1;

    fifo_bytepack #(.Depth(Depth), .MaxWriteBytes(MaxWB), .LittleEndian(1'b0)) u_be (
        .clk_i(clk_i), .reset_i(reset_i), .flush(flush),
        .write_enable(write_enable), .write_data(write_data), .write_width(write_width),
        .write_ready(ready0), .free_bytes(free0), .level(lvl0),
        .ack(ack), .data(data0), .have_next(hn0), .overflow(ovf0));

    fifo_bytepack #(.Depth(Depth), .MaxWriteBytes(MaxWB), .LittleEndian(1'b1)) u_le (
        .clk_i(clk_i), .reset_i(reset_i), .flush(flush),
        .write_enable(write_enable), .write_data(write_data), .write_width(write_width),
        .write_ready(ready1), .free_bytes(free1), .level(lvl1),
        .ack(ack), .data(data1), .have_next(hn1), .overflow(ovf1));

    always #5 clk_i = ~clk_i;

    int unsigned checks = 0;
    int unsigned errors = 0;
    bit          chk_en = 1'b0;

    // Reference model: the byte queues of both instances and the sticky flag.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         movf = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        int unsigned sz;
        sz = q0.size();
        check("be_level", 32'(lvl0), sz);
        check("be_free", 32'(free0), Depth - sz);
        check("be_ready", 32'(ready0), 32'((Depth - sz) >= MaxWB));
        check("be_have_next", 32'(hn0), 32'(sz != 0));
        check("be_overflow", 32'(ovf0), 32'(movf));
        if (sz != 0) check("be_data", 32'(data0), 32'(q0[0]));
        sz = q1.size();
        check("le_level", 32'(lvl1), sz);
        check("le_free", 32'(free1), Depth - sz);
        check("le_ready", 32'(ready1), 32'((Depth - sz) >= MaxWB));
        check("le_have_next", 32'(hn1), 32'(sz != 0));
        check("le_overflow", 32'(ovf1), 32'(movf));
        if (sz != 0) check("le_data", 32'(data1), 32'(q1[0]));
    endtask

    // Applies the FIFO rules to the model for one clock edge.
    task automatic model_step();
        int unsigned w;
        int unsigned sz;
        bit          pop;
        w  = 32'(write_width);
        sz = q0.size();
        if (reset_i || flush) begin
            q0.delete();
            q1.delete();
            movf = 1'b0;
        end else begin
            pop = ack && (sz != 0);
            if (pop) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            if (write_enable && w != 0) begin
                if (w > MaxWB || w > Depth - sz) begin
                    movf = 1'b1;
                end else begin
                    for (int unsigned k = 0; k < w; k++) begin
                        q0.push_back(write_data[(w-1-k)*8 +: 8]);
                        q1.push_back(write_data[k*8 +: 8]);
                    end
                end
            end
        end
    endtask

    task automatic cyc(input logic rst, input logic fl, input logic we,
                       input logic [31:0] wd, input logic [2:0] ww, input logic ak);
        reset_i      = rst;
        flush        = fl;
        write_enable = we;
        write_data   = wd;
        write_width  = ww;
        ack          = ak;
        @(negedge clk_i);
        if (chk_en) check_all();
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    task automatic wr(input logic [31:0] wd, input logic [2:0] ww);
        cyc(1'b0, 1'b0, 1'b1, wd, ww, 1'b0);
    endtask

    task automatic pop_n(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 1'b1);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 3'd0, 1'b0);
    endtask

    task automatic fill16();
        wr(32'h00010203, 3'd4);
        wr(32'h04050607, 3'd4);
        wr(32'h08090A0B, 3'd4);
        wr(32'h0C0D0E0F, 3'd4);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk_en = 1'b1;
        do_reset();
        check("rst_data_be", 32'(data0), 32'h0);
        check("rst_data_le", 32'(data1), 32'h0);
        check("rst_free", 32'(free0), 32'd16);

        // Three-byte write and its emission order on both instances.
        wr(32'h00AABBCC, 3'd3);
        check("w3_level", 32'(lvl0), 32'd3);
        check("w3_be_b0", 32'(data0), 32'hAA);
        check("w3_le_b0", 32'(data1), 32'hCC);
        pop_n(1);
        check("w3_be_b1", 32'(data0), 32'hBB);
        check("w3_le_b1", 32'(data1), 32'hBB);
        pop_n(1);
        check("w3_be_b2", 32'(data0), 32'hCC);
        check("w3_le_b2", 32'(data1), 32'hAA);
        pop_n(1);
        check("w3_empty", 32'(hn0), 32'd0);
        // ack on an empty FIFO is ignored
        pop_n(1);

        // Full FIFO, a rejected write, then a full drain.
        fill16();
        check("full_level", 32'(lvl0), 32'd16);
        check("full_ready", 32'(ready0), 32'd0);
        wr(32'h000000FF, 3'd1);
        check("full_ovf", 32'(ovf0), 32'd1);
        check("full_head", 32'(data0), 32'h00);
        pop_n(16);
        check("drain_empty", 32'(hn0), 32'd0);

        // A four-byte write that wraps around the end of the array.
        do_reset();
        fill16();
        pop_n(14);
        wr(32'h11223344, 3'd4);
        check("wrap_level", 32'(lvl0), 32'd6);
        check("wrap_head", 32'(data0), 32'h0E);
        pop_n(2);
        check("wrap_be_11", 32'(data0), 32'h11);
        check("wrap_le_44", 32'(data1), 32'h44);
        pop_n(4);

        // Same-cycle write and ack: free space is not credited for the pop.
        do_reset();
        wr(32'h01020304, 3'd4);
        wr(32'h05060708, 3'd4);
        wr(32'h090A0B0C, 3'd4);
        wr(32'h0000000D, 3'd1);
        cyc(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 3'd4, 1'b1);
        check("l13_rej_level", 32'(lvl0), 32'd12);
        check("l13_rej_ovf", 32'(ovf0), 32'd1);
        wr(32'h0000000E, 3'd1);
        cyc(1'b0, 1'b0, 1'b1, 32'h00A1B2C3, 3'd3, 1'b1);
        check("l13_acc_level", 32'(lvl0), 32'd15);

        // Flush with write and ack asserted in the same cycle.
        do_reset();
        wr(32'h01020304, 3'd4);
        wr(32'h00050607, 3'd3);
        wr(32'h12345678, 3'd5);
        check("fl_pre_ovf", 32'(ovf0), 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 32'h99999999, 3'd2, 1'b1);
        check("fl_level", 32'(lvl0), 32'd0);
        check("fl_have_next", 32'(hn0), 32'd0);
        check("fl_ovf", 32'(ovf0), 32'd0);
        wr(32'h0000005A, 3'd1);
        check("fl_5a_be", 32'(data0), 32'h5A);
        check("fl_5a_le", 32'(data1), 32'h5A);

        // Reset in the middle of a drain.
        wr(32'h61626364, 3'd4);
        pop_n(2);
        cyc(1'b1, 1'b0, 1'b1, 32'h77777777, 3'd2, 1'b1);
        check("mid_rst_data", 32'(data0), 32'h0);
        check("mid_rst_level", 32'(lvl0), 32'd0);
        check("mid_rst_free", 32'(free0), 32'd16);

        // Random traffic, light drain first and then heavier drain.
        for (int unsigned i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 63) == 0,
                $urandom_range(0, 3) != 0,
                $urandom,
                3'($urandom_range(0, 6)),
                (i < 1500) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7));
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
